pll_fracdiv: RTL and testbench
==============================

PLL_FRACDIV -- requirements
Module: pll_fracdiv

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of clock-enable channels, legal range 1..4.
REQ-002 SHALL have parameter ACC_W, default 24: phase-accumulator width in bits, legal range 8..32.
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024: consecutive pll_locked-high cycles required before ready, legal range 1..65535.
REQ-004 SHALL have parameter INC_DEFAULT, default 2**(ACC_W-1): reset increment of every channel (divide-by-2).
REQ-005 SHALL have port refclk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset (0 = in reset).
REQ-007 SHALL have port pll_locked  input  1  lock flag from upstream PLL, asynchronous; double-flop synchronised internally.
REQ-008 SHALL have port cfg_valid  input  1  config write request.
REQ-009 SHALL have port cfg_ready  output  1  config write can be accepted.
REQ-010 SHALL have port cfg_ch  input  2  target channel index.
REQ-011 SHALL have port cfg_inc  input  ACC_W  new phase increment.
REQ-012 SHALL have port ce  output  NUM_CH  one-cycle clock-enable pulse per channel.
REQ-013 SHALL have port sq  output  NUM_CH  per-channel square wave, toggles on each ce pulse.
REQ-014 SHALL have port ready  output  1  outputs valid, lock stable.

Function
REQ-015 SHALL implement FSM states WAIT_LOCK and RUN; reset state WAIT_LOCK.
REQ-016 WAIT_LOCK SHALL count consecutive cycles with synchronised lock high; any low sample clears the count to 0.
REQ-017 WAIT_LOCK SHALL transition to RUN on the edge where the count reaches LOCK_CYCLES; ready is registered and asserts that same edge.
REQ-018 RUN SHALL transition to WAIT_LOCK on the first edge the synchronised lock is sampled low; ready, ce, sq, and all accumulators clear on that edge.
REQ-019 In WAIT_LOCK, ce and sq SHALL be held 0 and accumulators held at 0.
REQ-020 In RUN, each channel SHALL compute acc + inc in ACC_W+1 bits per cycle, store the low ACC_W bits, and register the carry as ce on the same edge.
REQ-021 Output rate SHALL be f_ce = f_refclk * inc / 2**ACC_W; sq frequency is f_ce / 2; inc = 0 yields no ce pulses and static sq.
REQ-022 The first ce pulse SHALL occur no earlier than the edge after ready asserts.
REQ-023 cfg_ready SHALL be 1 whenever rst is deasserted, in both states.
REQ-024 A write SHALL be accepted on an edge with cfg_valid & cfg_ready; the new inc is used from the next edge.
REQ-025 A write SHALL leave that channel's accumulator and sq unchanged (glitch-free frequency change).
REQ-026 On a write coinciding with an accumulate edge, that edge SHALL use the old inc.
REQ-027 A write with cfg_ch >= NUM_CH SHALL be accepted and ignored.
REQ-028 Increment registers SHALL survive lock loss; only rst restores INC_DEFAULT.
REQ-029 Channels SHALL be independent; ce pulses on several channels in the same cycle are legal.

Reset
REQ-030 Asserting rst SHALL immediately (asynchronously) set state WAIT_LOCK, lock count 0, synchroniser 0, accumulators 0, inc = INC_DEFAULT, ce = 0, sq = 0, ready = 0, cfg_ready = 0.
REQ-031 Deassertion of rst SHALL be usable at any time relative to refclk; the first post-reset edge behaves as WAIT_LOCK with count 0.
REQ-032 rst asserted mid-RUN SHALL abandon all state with no further ce pulses; relock requires the full LOCK_CYCLES again.

Verification (ACC_W=8, NUM_CH=2, LOCK_CYCLES=4)
REQ-033 Release rst, hold pll_locked=1 -> ready rises on the 4th edge after the synchronised lock goes high; ce=0 before that edge.
REQ-034 RUN, ch0 inc=64 -> ce[0] pulses every 4 cycles, sq[0] period 8 cycles 50% duty; ch1 default inc=128 -> ce[1] every 2 cycles.
REQ-035 inc=255 -> 255 pulses per 256 cycles; inc=0 -> no pulses over 512 cycles.
REQ-036 Drop pll_locked for 1 cycle in RUN -> ready/ce/sq 0 two edges later (synchroniser delay); ready reasserts 4 edges after synchronised relock; inc values retained.
REQ-037 Write cfg_ch=3 inc=1 -> no channel changes; write ch0 inc=32 on an overflow edge -> that pulse present, next pulse 8 cycles later, sq[0] continuous.
REQ-038 Assert rst mid-RUN between edges -> all outputs 0 immediately, before the next refclk edge.

Source files
------------

// File: rtl/pll_fracdiv.sv
// ============================================================================
// pll_fracdiv : lock-qualified fractional clock-enable generator
//               (per-channel phase accumulators, CE pulses and square waves)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_fracdiv #(
  parameter int                NUM_CH      = 2,
  parameter int                ACC_W       = 24,
  parameter int                LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0]  INC_DEFAULT = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              ready
);

  typedef enum logic [0:0] {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        sync1_q, sync2_q;
  logic        run_en;
  logic        cfg_accept;

  // Two-flop synchroniser for the asynchronous PLL lock flag
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= 16'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      WAIT_LOCK: begin
        ready_d = 1'b0;
        if (sync2_q) begin
          if (cnt_q == LOCK_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = 16'd0;
        end
      end
      RUN: begin
        if (!sync2_q) begin
          state_d = WAIT_LOCK;
          ready_d = 1'b0;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        ready_d = 1'b0;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Accumulators only advance while running with lock still present;
  // the lock-loss edge itself clears them together with ready.
  assign run_en     = (state_q == RUN) && sync2_q;
  assign cfg_ready  = rst;
  assign cfg_accept = cfg_valid & cfg_ready;
  assign ready      = ready_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             ce_q, ce_d;
    logic             sq_q, sq_d;
    logic [ACC_W:0]   sum;

    always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, inc_q};
      acc_d = '0;
      ce_d  = 1'b0;
      sq_d  = 1'b0;
      inc_d = inc_q;
      if (run_en) begin
        acc_d = sum[ACC_W-1:0];
        ce_d  = sum[ACC_W];
        sq_d  = sq_q ^ sum[ACC_W];
      end
      // Out-of-range channel indices never match and are silently dropped
      if (cfg_accept && (cfg_ch == 2'(g))) begin
        inc_d = cfg_inc;
      end
    end

    always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
        acc_q <= '0;
        inc_q <= INC_DEFAULT;
        ce_q  <= 1'b0;
        sq_q  <= 1'b0;
      end else begin
        acc_q <= acc_d;
        inc_q <= inc_d;
        ce_q  <= ce_d;
        sq_q  <= sq_d;
      end
    end

    assign ce[g] = ce_q;
    assign sq[g] = sq_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_fracdiv.sv
// ============================================================================
// tb_pll_fracdiv : self-checking bench for pll_fracdiv (ACC_W=8, NUM_CH=2)
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_fracdiv;

  localparam int NCH  = 2;
  localparam int AW   = 8;
  localparam int LOCK = 4;
  localparam int MOD  = 1 << AW;

  logic           refclk = 1'b0;
  logic           rst = 1'b0;
  logic           pll_locked = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = 2'd0;
  logic [AW-1:0]  cfg_inc = '0;
  logic [NCH-1:0] ce, sq;
  logic           ready;

  int tests = 0;
  int fails = 0;

  pll_fracdiv #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LOCK)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .ce(ce), .sq(sq), .ready(ready)
  );

  always #5 refclk = ~refclk;

  // Reference model: phase as plain integers modulo 2**ACC_W
  int       m_s1, m_s2, m_cnt;
  bit       m_run, m_ready;
  int       m_acc[NCH];
  int       m_inc[NCH];
  bit [1:0] m_ce, m_sq;
  int       ce_cnt[NCH];
  int       sq_hi[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_cnt = 0; m_run = 0; m_ready = 0;
    m_ce = '0; m_sq = '0;
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0;
      m_inc[c] = MOD / 2;
    end
  endtask

  task automatic model_edge();
    int lk;
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(pll_locked);
    if (!m_run) begin
      m_ce = '0; m_sq = '0;
      for (int c = 0; c < NCH; c++) m_acc[c] = 0;
      if (lk != 0) begin
        m_cnt++;
        if (m_cnt == LOCK) begin
          m_run = 1; m_ready = 1; m_cnt = 0;
        end
      end else begin
        m_cnt = 0;
      end
    end else if (lk == 0) begin
      m_run = 0; m_ready = 0; m_cnt = 0;
      m_ce = '0; m_sq = '0;
      for (int c = 0; c < NCH; c++) m_acc[c] = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        int t;
        t        = m_acc[c] + m_inc[c];
        m_ce[c]  = (t >= MOD);
        m_acc[c] = t % MOD;
        if (m_ce[c]) m_sq[c] = ~m_sq[c];
      end
    end
    if (cfg_valid && (int'(cfg_ch) < NCH)) m_inc[cfg_ch] = int'(cfg_inc);
  endtask

  task automatic clr_counts();
    for (int c = 0; c < NCH; c++) begin
      ce_cnt[c] = 0;
      sq_hi[c]  = 0;
    end
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
    chk("ce", 32'(ce), 32'(m_ce));
    chk("sq", 32'(sq), 32'(m_sq));
    chk("ready", 32'(ready), 32'(m_ready));
    for (int c = 0; c < NCH; c++) begin
      ce_cnt[c] += int'(ce[c]);
      sq_hi[c]  += int'(sq[c]);
    end
  endtask

  task automatic wr(input int ch, input int inc);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_inc   = AW'(inc);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int       gap;
    bit       found;
    logic     sq0_start;
    model_reset();
    clr_counts();

    // Reset state
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    #3 rst = 1'b1;
    #1 chk("cfg_ready_up", 32'(cfg_ready), 32'd1);

    // Lock acquisition: 2 sync edges + LOCK counting edges
    repeat (2) step();
    pll_locked = 1'b1;
    repeat (5) step();
    chk("ready_early", 32'(ready), 32'd0);
    chk("ce_before_ready", 32'(ce), 32'd0);
    step();
    chk("ready_rise", 32'(ready), 32'd1);

    // ch0 inc=64, ch1 default 128
    wr(0, 64);
    clr_counts();
    repeat (256) step();
    chk("ce0_rate64", 32'(ce_cnt[0]), 32'd64);
    chk("ce1_rate128", 32'(ce_cnt[1]), 32'd128);
    chk("sq0_duty", 32'(sq_hi[0]), 32'd128);
    chk("sq1_duty", 32'(sq_hi[1]), 32'd128);

    // Write to non-existent channel is ignored
    wr(3, 1);
    clr_counts();
    repeat (64) step();
    chk("ch3_ignored_ce0", 32'(ce_cnt[0]), 32'd16);
    chk("ch3_ignored_ce1", 32'(ce_cnt[1]), 32'd32);

    // Extremes
    wr(0, 255);
    clr_counts();
    repeat (256) step();
    chk("ce0_inc255", 32'(ce_cnt[0]), 32'd255);
    wr(0, 0);
    clr_counts();
    sq0_start = sq[0];
    repeat (512) step();
    chk("ce0_inc0", 32'(ce_cnt[0]), 32'd0);
    chk("sq0_static", 32'(sq[0]), 32'(sq0_start));

    // One-cycle lock drop
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    chk("ready_hold_sync", 32'(ready), 32'd1);
    step();
    chk("ready_drop", 32'(ready), 32'd0);
    chk("ce_drop", 32'(ce), 32'd0);
    chk("sq_drop", 32'(sq), 32'd0);
    wr(0, 64);
    repeat (2) step();
    chk("relock_early", 32'(ready), 32'd0);
    step();
    chk("relock_ready", 32'(ready), 32'd1);

    // Rate change on an overflow edge
    for (int i = 0; i < 8; i++) begin
      if (m_run && (m_s2 != 0) && (m_acc[0] + m_inc[0] >= MOD)) break;
      step();
    end
    wr(0, 32);
    chk("ovf_pulse_kept", 32'(ce[0]), 32'd1);
    gap = 0;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (!found && ce[0]) begin
        gap   = i;
        found = 1'b1;
      end
    end
    chk("gap_after_change", 32'(gap), 32'd8);

    // Inc retained across lock loss (ch1 still default)
    clr_counts();
    repeat (256) step();
    chk("ce1_retained", 32'(ce_cnt[1]), 32'd128);

    // Randomized traffic checked cycle-by-cycle against the model
    repeat (400) begin
      cfg_valid  = ($urandom_range(3) == 0);
      cfg_ch     = 2'($urandom_range(3));
      cfg_inc    = AW'($urandom);
      pll_locked = ($urandom_range(63) != 0);
      step();
    end
    cfg_valid  = 1'b0;
    pll_locked = 1'b1;
    repeat (12) step();
    chk("pre_async_ready", 32'(ready), 32'd1);

    // Asynchronous reset between edges
    #3 rst = 1'b0;
    #1;
    chk("async_ce", 32'(ce), 32'd0);
    chk("async_sq", 32'(sq), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_cfg_ready", 32'(cfg_ready), 32'd0);
    model_reset();
    #2 rst = 1'b1;
    repeat (5) step();
    chk("post_rst_early", 32'(ready), 32'd0);
    step();
    chk("post_rst_ready", 32'(ready), 32'd1);
    repeat (16) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
